// File: rtl/cdma_despreader.sv
// Gold-code despreader: regenerates the 31-chip code, majority-votes each window into a bit, tracks lock.
// Optional code-phase search during acquisition is enabled with `define CDMA_DESPREADER_SLIP_EN.
`timescale 1ns/1ps
module cdma_despreader #(
  parameter int CHIPS_PER_BIT = 31,
  parameter int THRESH        = 28,
  parameter int LOCK_WINDOWS  = 2,
  parameter int MISS_MAX      = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       chip_i,
  input  logic       chip_valid_i,
  input  logic [4:0] seed_i,
  input  logic       load_i,
  output logic       bit_o,
  output logic       bit_valid_o,
  output logic       lock_o,
  output logic [7:0] agree_o,
  output logic       seed_zero_o
);
  localparam int CW = $clog2(CHIPS_PER_BIT + 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      lfsr_a_reg, lfsr_a_next;
  logic [4:0]      lfsr_b_reg, lfsr_b_next;
  logic [CW-1:0]   chip_cnt_reg, chip_cnt_next;
  logic [CW-1:0]   ones_cnt_reg, ones_cnt_next;
  logic [3:0]      good_cnt_reg, good_cnt_next;
  logic [3:0]      miss_cnt_reg, miss_cnt_next;
  logic            bit_reg, bit_next;
  logic            bit_valid_reg, bit_valid_next;
  logic [7:0]      agree_reg, agree_next;
  logic            slip_reg, slip_next;

  logic            gold, accept, despread, window_end, good_win, bit_win, advance;
  logic [CW-1:0]   ones_total, ones_other, agree_win;
  logic [3:0]      good_inc, miss_inc;

  assign gold       = lfsr_a_reg[4] ^ lfsr_b_reg[4];
  assign accept     = chip_valid_i && !load_i && (state_reg != IDLE);
  assign despread   = chip_i ^ gold;
  assign ones_total = ones_cnt_reg + CW'(despread);
  assign ones_other = CW'(CHIPS_PER_BIT) - ones_total;
  assign agree_win  = (ones_total > ones_other) ? ones_total : ones_other;
  assign bit_win    = {ones_total, 1'b0} > (CW+1)'(CHIPS_PER_BIT);
  assign good_win   = agree_win >= CW'(THRESH);
  assign window_end = accept && (chip_cnt_reg == CW'(CHIPS_PER_BIT - 1));
  assign good_inc   = (good_cnt_reg == 4'hF) ? good_cnt_reg : good_cnt_reg + 4'd1;
  assign miss_inc   = (miss_cnt_reg == 4'hF) ? miss_cnt_reg : miss_cnt_reg + 4'd1;

`ifdef CDMA_DESPREADER_SLIP_EN
  // A pending slip holds the code for one chip, retarding its phase by one.
  assign advance = accept && !slip_reg;
`else
  assign advance = accept;
`endif

  always_comb begin
    state_next     = state_reg;
    lfsr_a_next    = lfsr_a_reg;
    lfsr_b_next    = lfsr_b_reg;
    chip_cnt_next  = chip_cnt_reg;
    ones_cnt_next  = ones_cnt_reg;
    good_cnt_next  = good_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    bit_next       = bit_reg;
    bit_valid_next = 1'b0;
    agree_next     = agree_reg;
    slip_next      = slip_reg;

    if (load_i) begin
      lfsr_a_next   = seed_i;
      lfsr_b_next   = seed_i;
      chip_cnt_next = '0;
      ones_cnt_next = '0;
      good_cnt_next = '0;
      miss_cnt_next = '0;
      slip_next     = 1'b0;
      state_next    = ACQ;
    end else if (accept) begin
      if (advance) begin
        lfsr_a_next = {lfsr_a_reg[3:0], lfsr_a_reg[4] ^ lfsr_a_reg[3] ^ lfsr_a_reg[2] ^ lfsr_a_reg[1]};
        lfsr_b_next = {lfsr_b_reg[3:0], lfsr_b_reg[4] ^ lfsr_b_reg[1]};
      end
      slip_next = 1'b0;
      if (window_end) begin
        chip_cnt_next  = '0;
        ones_cnt_next  = '0;
        bit_next       = bit_win;
        bit_valid_next = 1'b1;
        agree_next     = 8'(agree_win);
        if (state_reg == ACQ) begin
          if (good_win) begin
            good_cnt_next = good_inc;
            if (good_inc >= 4'(LOCK_WINDOWS)) state_next = LOCKED;
          end else begin
            good_cnt_next = '0;
`ifdef CDMA_DESPREADER_SLIP_EN
            slip_next = 1'b1;
`endif
          end
        end else begin
          if (good_win) begin
            miss_cnt_next = '0;
          end else if (miss_inc >= 4'(MISS_MAX)) begin
            miss_cnt_next = '0;
            good_cnt_next = '0;
            state_next    = ACQ;
          end else begin
            miss_cnt_next = miss_inc;
          end
        end
      end else begin
        chip_cnt_next = chip_cnt_reg + CW'(1);
        ones_cnt_next = ones_total;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      lfsr_a_reg    <= '0;
      lfsr_b_reg    <= '0;
      chip_cnt_reg  <= '0;
      ones_cnt_reg  <= '0;
      good_cnt_reg  <= '0;
      miss_cnt_reg  <= '0;
      bit_reg       <= 1'b0;
      bit_valid_reg <= 1'b0;
      agree_reg     <= '0;
      slip_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lfsr_a_reg    <= lfsr_a_next;
      lfsr_b_reg    <= lfsr_b_next;
      chip_cnt_reg  <= chip_cnt_next;
      ones_cnt_reg  <= ones_cnt_next;
      good_cnt_reg  <= good_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      bit_reg       <= bit_next;
      bit_valid_reg <= bit_valid_next;
      agree_reg     <= agree_next;
      slip_reg      <= slip_next;
    end
  end

  // Lock changes on the same edge as the window pulse that causes it.
  assign lock_o      = (state_reg == LOCKED);
  assign bit_o       = bit_reg;
  assign bit_valid_o = bit_valid_reg;
  assign agree_o     = agree_reg;
  assign seed_zero_o = (seed_i == 5'd0);
endmodule

// File: tb/tb_cdma_despreader.sv
// Directed bench for cdma_despreader: transmitter model drives chips, windows checked at each pulse.
`timescale 1ns/1ps
module tb_cdma_despreader;
  localparam int CPB = 31;

  logic       clk_i = 1'b0;
  logic       rst_i, chip_i, chip_valid_i, load_i;
  logic [4:0] seed_i;
  logic       bit_o, bit_valid_o, lock_o, seed_zero_o;
  logic [7:0] agree_o;

  cdma_despreader dut (
    .clk_i(clk_i), .rst_i(rst_i), .chip_i(chip_i), .chip_valid_i(chip_valid_i),
    .seed_i(seed_i), .load_i(load_i), .bit_o(bit_o), .bit_valid_o(bit_valid_o),
    .lock_o(lock_o), .agree_o(agree_o), .seed_zero_o(seed_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_pulse = 0;
  logic [4:0] tx_a, tx_b;

  always @(posedge clk_i) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic ld);
    chip_i = c; chip_valid_i = v; load_i = ld;
    tick();
  endtask

  // Transmitter model: chip = data ^ gold, code runs continuously across bits.
  task automatic tx_next(input logic b, output logic c);
    c    = b ^ tx_a[4] ^ tx_b[4];
    tx_a = {tx_a[3:0], tx_a[4] ^ tx_a[3] ^ tx_a[2] ^ tx_a[1]};
    tx_b = {tx_b[3:0], tx_b[4] ^ tx_b[1]};
  endtask

  task automatic load_seed(input logic [4:0] s);
    seed_i = s; tx_a = s; tx_b = s;
    drive(1'b1, 1'b1, 1'b1);
    chip_valid_i = 1'b0; load_i = 1'b0;
  endtask

  task automatic send_window(input string tag, input logic b, input int nflip, input bit gap,
                             input logic [7:0] exp_agree, input logic exp_lock);
    logic c;
    int early = 0;
    for (int i = 0; i < CPB; i++) begin
      tx_next(b, c);
      if (i < nflip) c = ~c;
      drive(c, 1'b1, 1'b0);
      if (i < CPB - 1) begin
        if (bit_valid_o) early++;
        if (gap) begin
          drive(~c, 1'b0, 1'b0);
          if (bit_valid_o) early++;
        end
      end
    end
    check({tag, "_valid"}, bit_valid_o, 1'b1);
    last_pulse = cyc;
    check({tag, "_bit"}, bit_o, b);
    check({tag, "_agree"}, agree_o, exp_agree);
    check({tag, "_lock"}, lock_o, exp_lock);
    check({tag, "_early"}, early, 0);
    if (gap) begin
      drive(1'b0, 1'b0, 1'b0);
      check({tag, "_pulse_len"}, bit_valid_o, 1'b0);
    end
  endtask

  initial begin
    int p1, cnt, k;
    logic c, exp_lock;

    // Reset with chip_valid and load held high
    rst_i = 1'b1; chip_i = 1'b1; chip_valid_i = 1'b1; load_i = 1'b1; seed_i = 5'b10101;
    repeat (3) tick();
    check("rst_bit", bit_o, 1'b0);
    check("rst_valid", bit_valid_o, 1'b0);
    check("rst_lock", lock_o, 1'b0);
    check("rst_agree", agree_o, 8'd0);
    check("seed_nz", seed_zero_o, 1'b0);

    // IDLE ignores chips
    rst_i = 1'b0; load_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      drive(i[0], 1'b1, 1'b0);
      if (bit_valid_o || lock_o) cnt++;
    end
    check("idle_quiet", cnt, 0);

    // Clean lock
    load_seed(5'b10101);
    send_window("w1", 1'b1, 0, 1'b0, 8'd31, 1'b0);
    p1 = last_pulse;
    send_window("w2", 1'b0, 0, 1'b0, 8'd31, 1'b1);
    check("w_spacing", last_pulse - p1, 31);
    send_window("w3", 1'b1, 0, 1'b0, 8'd31, 1'b1);
    send_window("w4", 1'b1, 0, 1'b0, 8'd31, 1'b1);

    // Chip errors: 3 per window keeps lock, 4 per window drops it on the third
    send_window("e3a", 1'b0, 3, 1'b0, 8'd28, 1'b1);
    send_window("e3b", 1'b1, 3, 1'b0, 8'd28, 1'b1);
    send_window("e4a", 1'b1, 4, 1'b0, 8'd27, 1'b1);
    send_window("e4b", 1'b0, 4, 1'b0, 8'd27, 1'b1);
    send_window("e4c", 1'b1, 4, 1'b0, 8'd27, 1'b0);

    // Alternate-cycle valid: pulses 62 cycles apart, relock after two good windows
    send_window("g1", 1'b0, 0, 1'b1, 8'd31, 1'b0);
    p1 = last_pulse;
    send_window("g2", 1'b1, 0, 1'b1, 8'd31, 1'b1);
    check("g_spacing", last_pulse - p1, 62);

    // Mid-window reload while locked
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tx_next(1'b1, c);
      drive(c, 1'b1, 1'b0);
      if (bit_valid_o) cnt++;
    end
    check("rl_prelock", lock_o, 1'b1);
    load_seed(5'b10101);
    check("rl_lock", lock_o, 1'b0);
    check("rl_partial", cnt + int'(bit_valid_o), 0);
    send_window("rl", 1'b1, 0, 1'b0, 8'd31, 1'b0);

    // Seed zero: code is all zero, chips pass straight through
    seed_i = 5'd0;
    #1;
    check("seed_zero", seed_zero_o, 1'b1);
    load_seed(5'd0);
    send_window("z1", 1'b0, 0, 1'b0, 8'd31, 1'b0);
    send_window("z2", 1'b1, 0, 1'b0, 8'd31, 1'b1);

    // Stream delayed two chips relative to load, constant data 1
    load_seed(5'b10101);
    k = 0;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < CPB; i++) begin
        if (k < 2) c = 1'b0;
        else tx_next(1'b1, c);
        k++;
        drive(c, 1'b1, 1'b0);
      end
      check($sformatf("slip_w%0d_valid", w), bit_valid_o, 1'b1);
`ifdef CDMA_DESPREADER_SLIP_EN
      exp_lock = (w >= 3);
      if (w >= 2) check($sformatf("slip_w%0d_bit", w), bit_o, 1'b1);
`else
      exp_lock = 1'b0;
`endif
      check($sformatf("slip_w%0d_lock", w), lock_o, exp_lock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdma_despreader.md
Name: cdma_despreader

Overview:
- Receive-side counterpart of the CDMA spreader.
- Regenerates the same 31-chip Gold code from two 5-bit LFSRs loaded with a shared seed, and XORs each incoming chip with the code (despreading).
- Majority-votes each window of CHIPS_PER_BIT chips to recover one data bit, and maintains a lock indication from window agreement quality.
- Sits between the chip input pin and the data-bit sink.

Parameters:
- CHIPS_PER_BIT, 31: chips per data bit (window length); range 3..255.
- THRESH, 28: minimum agreement for a window to count as good; range CHIPS_PER_BIT/2+1..CHIPS_PER_BIT.
- LOCK_WINDOWS, 2: consecutive good windows needed to declare lock; range 1..15.
- MISS_MAX, 3: consecutive bad windows that drop lock; range 1..15.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- chip_i  in  1  received chip
- chip_valid_i  in  1  chip_i is valid this cycle
- seed_i  in  5  LFSR seed, shared with the transmitter
- load_i  in  1  load seed_i into both LFSRs and restart acquisition
- bit_o  out  1  recovered data bit
- bit_valid_o  out  1  one-cycle pulse: bit_o updated
- lock_o  out  1  receiver locked
- agree_o  out  8  agreement count of the last completed window
- seed_zero_o  out  1  combinational: seed_i == 0

Behaviour:
- Reset (rst_i=1 at a clock edge) sets:
  - both LFSRs to 0; chip_cnt, ones_cnt, good_cnt, miss_cnt to 0;
  - bit_o, bit_valid_o, lock_o and agree_o to 0;
  - state to IDLE.
- LFSR A advances as A <= {A[3:0], A[4]^A[3]^A[2]^A[1]}.
- LFSR B advances as B <= {B[3:0], B[4]^B[1]}.
- gold = A[4]^B[4]. The LFSRs advance only on an accepted chip (chip_valid_i=1 in ACQ or LOCKED).
- load_i=1, any state:
  - A and B are set to seed_i; chip_cnt, ones_cnt, good_cnt and miss_cnt clear; lock_o is 0; state goes to ACQ.
  - A chip_valid_i in the same cycle is discarded.
  - load_i has priority over chip_valid_i; rst_i has priority over everything.
- IDLE: chips are ignored and the LFSRs hold. bit_valid_o and lock_o stay 0.
- Accepted chip: despread d = chip_i ^ gold (gold from current register values); ones_cnt += d; chip_cnt += 1.
- Window end occurs when the accepted chip has chip_cnt == CHIPS_PER_BIT-1. On the next cycle:
  - bit_o = (2*ones_total > CHIPS_PER_BIT), where ones_total includes the final chip;
  - agree_o = max(ones_total, CHIPS_PER_BIT - ones_total);
  - bit_valid_o = 1 for exactly one cycle;
  - chip_cnt and ones_cnt clear, so the next window starts with the following chip. There are no gaps.
- Latency: one clock from the final chip of a window to bit_valid_o.
- A window is good if agree_o >= THRESH, otherwise bad.
- ACQ transitions:
  - good window: good_cnt++; when good_cnt reaches LOCK_WINDOWS, go to LOCKED and set lock_o=1 in the same cycle as that window's bit_valid_o.
  - bad window: good_cnt = 0.
- LOCKED transitions:
  - good window: miss_cnt = 0.
  - bad window: miss_cnt++; when miss_cnt reaches MISS_MAX, go to ACQ, set lock_o=0 in the cycle of that bit_valid_o, and clear good_cnt and miss_cnt.
- bit_valid_o pulses in both ACQ and LOCKED; lock_o qualifies trust in bit_o.
- bit_o and agree_o hold between pulses.
- Counter widths:
  - chip_cnt and ones_cnt: $clog2(CHIPS_PER_BIT+1) bits;
  - agree_o: zero-extended to 8 bits;
  - good_cnt and miss_cnt: 4 bits, saturating.
- Seed 0: the LFSRs stay 0 and gold is 0, so despread is chip_i pass-through. This is legal; it is flagged by seed_zero_o=1.
- chip_valid_i gaps are allowed anywhere in a window; the state holds during gaps.

Optional Feature:
- Macro: CDMA_DESPREADER_SLIP_EN.
- Defined: in ACQ only, after each bad window, the first accepted chip of the next window uses the current gold value but the LFSRs do not advance on it. This retards the code phase by one chip per bad window, searching alignment. No slip occurs in LOCKED.
- Undefined: the LFSRs always advance on accepted chips; alignment depends solely on load_i timing.

Test Plan:
- Reset check: assert rst_i for 3 cycles with chip_valid_i=1 and load_i=1 → all outputs 0; state IDLE after release; no bit_valid_o while in IDLE.
- Clean lock: load seed 5'b10101, then feed transmitter-model chips for bits 1,0,1,1 with chip_valid_i continuous:
  - bit_valid_o pulses at cycles 31, 62, 93 and 124 after the first chip;
  - bit_o = 1,0,1,1; agree_o = 31;
  - lock_o rises with the 2nd pulse.
- Errors: after lock, flip 3 chips per window → agree_o = 28, bits correct, lock held. Then flip 4 chips per window → agree_o = 27; lock_o falls on the 3rd consecutive bad window.
- Gapped input: chip_valid_i on alternate cycles → same bits; pulses 62 cycles apart.
- Mid-window reload: assert load_i at chip 15 of a locked window with chip_valid_i=1 → that chip is dropped, lock_o=0, the next 31 accepted chips form a fresh window, and no bit_valid_o comes from the partial window.
- SLIP_EN: stream delayed by 2 chips relative to load → bad windows, slip after each; after 2 slips, windows are good, and lock_o rises LOCK_WINDOWS good windows later. With the macro undefined, lock_o never rises.
